// File: rtl/wb_commit_unit.sv
// wb_commit_unit - writeback/commit stage of the dual-issue MIPS core.
//
// Takes one issue bundle per valid/ready handshake. If the bundle has no
// load, it is committed to the register file on the next edge. If it has a
// load, all lane fields are latched and the unit waits in WAIT_MEM for the
// memory response. The response is byte-ordered, aligned and extended, then
// replaces the load lane's data, and every lane commits in one registered
// cycle. The unit also holds the architectural HI/LO pair.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid / in_ready  bundle handshake (see below)
//   in_wreg/in_wa/in_wdata  per-lane GPR enable, destination, ALU result
//   in_mreg              per-lane "result from memory" (one-hot or zero)
//   in_dre/in_sext/in_daddr  load byte enables, sign-extend, address
//   in_whilo/in_mthilo/in_hilo  HI/LO write enables, MTHI/MTLO select, mul/div result
//   mem_rvalid/mem_rdata load response, sampled only in WAIT_MEM
//   rf_we/rf_wa/rf_wd    registered register-file write port
//   hilo_o               current {HI, LO}
//   busy                 high while waiting for load data
//   dbg_state            FSM state (0 = IDLE, 1 = WAIT_MEM)
//
// Handshake: a bundle transfers on any rising edge where in_valid and
// in_ready are both high. in_ready depends only on state and resetn, never
// on in_valid, and the producer must hold the bundle stable until it
// transfers.
module wb_commit_unit #(
  parameter int          LANES     = 2,
  parameter bit          SWAP_RAM  = 1'b0,
  parameter bit          SWAP_CONF = 1'b0,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_wreg,
  input  logic [5*LANES-1:0]    in_wa,
  input  logic [32*LANES-1:0]   in_wdata,
  input  logic [LANES-1:0]      in_mreg,
  input  logic [3:0]            in_dre,
  input  logic                  in_sext,
  input  logic [31:0]           in_daddr,
  input  logic [1:0]            in_whilo,
  input  logic [1:0]            in_mthilo,
  input  logic [63:0]           in_hilo,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic [LANES-1:0]      rf_we,
  output logic [5*LANES-1:0]    rf_wa,
  output logic [32*LANES-1:0]   rf_wd,
  output logic [63:0]           hilo_o,
  output logic                  busy,
  output logic                  dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT_MEM = 1'b1} state_t;

  state_t state, state_next;
  logic   accept, commit, load_latch;

  // Bundle held while the load is outstanding
  logic [LANES-1:0]    l_wreg, l_mreg;
  logic [5*LANES-1:0]  l_wa;
  logic [32*LANES-1:0] l_wdata;
  logic [3:0]          l_dre;
  logic                l_sext;
  logic [31:0]         l_daddr;
  logic [1:0]          l_whilo, l_mthilo;
  logic [63:0]         l_hilo;

  // Bundle being committed this cycle: live inputs in IDLE, latched in WAIT_MEM
  logic [LANES-1:0]    c_wreg, c_we;
  logic [5*LANES-1:0]  c_wa;
  logic [32*LANES-1:0] c_wdata, c_wd;
  logic [1:0]          c_whilo, c_mthilo;
  logic [63:0]         c_hilo;

  logic        is_conf, do_swap, hi_we, lo_we;
  logic [31:0] dm, ld, hi_val, lo_val;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (accept && (|in_mreg)) state_next = S_WAIT_MEM;
      S_WAIT_MEM: if (mem_rvalid)           state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = resetn && (state == S_IDLE);
    busy       = (state == S_WAIT_MEM);
    dbg_state  = (state == S_WAIT_MEM);
    load_latch = (state == S_IDLE) && accept && (|in_mreg);
    commit     = ((state == S_IDLE) && accept && !(|in_mreg)) ||
                 ((state == S_WAIT_MEM) && mem_rvalid);
  end

  assign c_wreg   = busy ? l_wreg   : in_wreg;
  assign c_wa     = busy ? l_wa     : in_wa;
  assign c_wdata  = busy ? l_wdata  : in_wdata;
  assign c_whilo  = busy ? l_whilo  : in_whilo;
  assign c_mthilo = busy ? l_mthilo : in_mthilo;
  assign c_hilo   = busy ? l_hilo   : in_hilo;

  // Load data: byte order depends on whether the address hits confreg
  always_comb begin
    is_conf = ((l_daddr & CONF_MASK) == CONF_BASE);
    do_swap = is_conf ? SWAP_CONF : SWAP_RAM;
    dm      = do_swap ? {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}
                      : mem_rdata;
    case (l_dre)
      4'b1111: ld = dm;
      4'b0011: ld = {{16{l_sext & dm[15]}}, dm[15:0]};
      4'b1100: ld = {{16{l_sext & dm[31]}}, dm[31:16]};
      4'b0001: ld = {{24{l_sext & dm[7]}},  dm[7:0]};
      4'b0010: ld = {{24{l_sext & dm[15]}}, dm[15:8]};
      4'b0100: ld = {{24{l_sext & dm[23]}}, dm[23:16]};
      4'b1000: ld = {{24{l_sext & dm[31]}}, dm[31:24]};
      default: ld = 32'h0;
    endcase
  end

  // Per-lane write data and enables. When two enabled lanes target the same
  // register, the older (lower) lane is suppressed so the younger one wins.
  always_comb begin
    c_wd = c_wdata;
    c_we = '0;
    for (int i = 0; i < LANES; i++) begin
      if (busy && l_mreg[i]) c_wd[32*i +: 32] = ld;
      c_we[i] = c_wreg[i] && (c_wa[5*i +: 5] != 5'd0);
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (c_wreg[j] && (c_wa[5*j +: 5] == c_wa[5*i +: 5])) c_we[i] = 1'b0;
      end
    end
  end

  // HI/LO: MTHI/MTLO take lane-0 data, otherwise the mul/div result.
  // mthilo = 11 is not a legal encoding and writes nothing.
  always_comb begin
    hi_we  = c_whilo[1] && (c_mthilo != 2'b11);
    lo_we  = c_whilo[0] && (c_mthilo != 2'b11);
    hi_val = (c_mthilo == 2'b10) ? c_wdata[31:0] : c_hilo[63:32];
    lo_val = (c_mthilo == 2'b01) ? c_wdata[31:0] : c_hilo[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      l_wreg   <= '0;
      l_mreg   <= '0;
      l_wa     <= '0;
      l_wdata  <= '0;
      l_dre    <= '0;
      l_sext   <= 1'b0;
      l_daddr  <= '0;
      l_whilo  <= '0;
      l_mthilo <= '0;
      l_hilo   <= '0;
    end else if (load_latch) begin
      l_wreg   <= in_wreg;
      l_mreg   <= in_mreg;
      l_wa     <= in_wa;
      l_wdata  <= in_wdata;
      l_dre    <= in_dre;
      l_sext   <= in_sext;
      l_daddr  <= in_daddr;
      l_whilo  <= in_whilo;
      l_mthilo <= in_mthilo;
      l_hilo   <= in_hilo;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_we  <= '0;
      rf_wa  <= '0;
      rf_wd  <= '0;
      hilo_o <= '0;
    end else begin
      rf_we <= commit ? c_we : '0;
      if (commit) begin
        rf_wa <= c_wa;
        rf_wd <= c_wd;
        if (hi_we) hilo_o[63:32] <= hi_val;
        if (lo_we) hilo_o[31:0]  <= lo_val;
      end
    end
  end

endmodule
